// File: rtl/sw_debounce.sv
// Switch conditioning: per-bit two-flop synchroniser, stability-count debounce,
// registered clean levels and one-cycle rise/fall/change strobes.
module sw_debounce #(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw_in,
    output logic [WIDTH-1:0] sw_out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             change,
    output logic             settled
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_TERM = CW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] s1_q, s1_d;
    logic [WIDTH-1:0] s2_q, s2_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] rise_q, rise_d;
    logic [WIDTH-1:0] fall_q, fall_d;
    logic             change_q, change_d;
    logic [CW-1:0]    cnt_q [WIDTH];
    logic [CW-1:0]    cnt_d [WIDTH];
    logic [WIDTH-1:0] bit_idle;

    // A bit only moves to its synchronised level after that level has differed
    // for DEBOUNCE_CYCLES consecutive edges; any agreement restarts the count.
    always_comb begin
        s1_d   = sw_in;
        s2_d   = s1_q;
        out_d  = out_q;
        rise_d = '0;
        fall_d = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (s2_q[i] != out_q[i]) begin
                if (cnt_q[i] == CNT_TERM) begin
                    out_d[i]  = s2_q[i];
                    rise_d[i] = s2_q[i];
                    fall_d[i] = ~s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
        change_d = |(rise_d | fall_d);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_q     <= '0;
            s2_q     <= '0;
            out_q    <= '0;
            rise_q   <= '0;
            fall_q   <= '0;
            change_q <= 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            out_q    <= out_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            change_q <= change_d;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Settled is derived purely from registered state, so it never glitches on sw_in.
    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            bit_idle[i] = (cnt_q[i] == '0) && (s2_q[i] == out_q[i]);
        end
    end

    assign sw_out  = out_q;
    assign rise    = rise_q;
    assign fall    = fall_q;
    assign change  = change_q;
    assign settled = &bit_idle;

endmodule

// File: tb/tb_sw_debounce.sv
// Bench for sw_debounce: a default (16-cycle) and a short (4-cycle) instance are
// compared every cycle against a run-length model of the debounce rules.
module tb_sw_debounce;

    logic       clk;
    logic       rst;
    logic [7:0] sw_a, sw_b;
    logic [7:0] out_a, rise_a, fall_a;
    logic [7:0] out_b, rise_b, fall_b;
    logic       change_a, settled_a, change_b, settled_b;

    int checks;
    int failures;

    // model state, index 0 = default instance, 1 = short instance
    int         dc [2] = '{16, 4};
    logic [7:0] m_pipe1 [2];
    logic [7:0] m_pipe2 [2];
    logic [7:0] m_out   [2];
    logic [7:0] m_rise  [2];
    logic [7:0] m_fall  [2];
    int         m_run   [2][8];

    sw_debounce #(.WIDTH(8), .DEBOUNCE_CYCLES(16)) dut_def (
        .clk(clk), .rst(rst), .sw_in(sw_a), .sw_out(out_a), .rise(rise_a),
        .fall(fall_a), .change(change_a), .settled(settled_a)
    );

    sw_debounce #(.WIDTH(8), .DEBOUNCE_CYCLES(4)) dut_short (
        .clk(clk), .rst(rst), .sw_in(sw_b), .sw_out(out_b), .rise(rise_b),
        .fall(fall_b), .change(change_b), .settled(settled_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_model();
        for (int k = 0; k < 2; k++) begin
            m_pipe1[k] = '0;
            m_pipe2[k] = '0;
            m_out[k]   = '0;
            m_rise[k]  = '0;
            m_fall[k]  = '0;
            for (int b = 0; b < 8; b++) m_run[k][b] = 0;
        end
    endtask

    // The input reaches the comparison point two edges late; a level is accepted
    // on the edge where it has disagreed with the output for dc consecutive edges.
    task automatic model_edge();
        logic [7:0] s;
        if (!rst) begin
            clear_model();
            return;
        end
        for (int k = 0; k < 2; k++) begin
            s = (k == 0) ? sw_a : sw_b;
            m_rise[k] = '0;
            m_fall[k] = '0;
            for (int b = 0; b < 8; b++) begin
                if (m_pipe2[k][b] != m_out[k][b]) begin
                    m_run[k][b] = m_run[k][b] + 1;
                    if (m_run[k][b] == dc[k]) begin
                        m_out[k][b] = m_pipe2[k][b];
                        if (m_pipe2[k][b]) m_rise[k][b] = 1'b1;
                        else               m_fall[k][b] = 1'b1;
                        m_run[k][b] = 0;
                    end
                end else begin
                    m_run[k][b] = 0;
                end
            end
            m_pipe2[k] = m_pipe1[k];
            m_pipe1[k] = s;
        end
    endtask

    task automatic check_one(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_int(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic logic exp_settled(input int k);
        logic s = 1'b1;
        for (int b = 0; b < 8; b++) begin
            if (m_run[k][b] != 0 || m_pipe2[k][b] != m_out[k][b]) s = 1'b0;
        end
        return s;
    endfunction

    task automatic checkOutput();
        check_one("def.sw_out",  out_a, m_out[0]);
        check_one("def.rise",    rise_a, m_rise[0]);
        check_one("def.fall",    fall_a, m_fall[0]);
        check_one("def.change",  {7'b0, change_a},  {7'b0, |(m_rise[0] | m_fall[0])});
        check_one("def.settled", {7'b0, settled_a}, {7'b0, exp_settled(0)});
        check_one("short.sw_out",  out_b, m_out[1]);
        check_one("short.rise",    rise_b, m_rise[1]);
        check_one("short.fall",    fall_b, m_fall[1]);
        check_one("short.change",  {7'b0, change_b},  {7'b0, |(m_rise[1] | m_fall[1])});
        check_one("short.settled", {7'b0, settled_b}, {7'b0, exp_settled(1)});
    endtask

    task automatic run_cycle();
        @(posedge clk);
        model_edge();
        #1;
        checkOutput();
    endtask

    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input int n);
        sw_a = a;
        sw_b = b;
        repeat (n) run_cycle();
    endtask

    // Counts edges (the first sampling edge included) until the chosen output equals target.
    task automatic wait_out(input int k, input logic [7:0] target, input int exp_edges, input string tag);
        int n = 0;
        while (((k == 0) ? out_a : out_b) !== target && n < 60) begin
            run_cycle();
            n++;
        end
        check_int(tag, n, exp_edges);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst  = 1'b0;
        sw_a = 8'hFF;
        sw_b = 8'hFF;
        clear_model();
        #2;
        $display("[TB] reset held with sw_in = FF");
        repeat (5) run_cycle();

        // release; E plus 17 further edges = 18 edges counted for the default instance
        rst = 1'b1;
        wait_out(0, 8'hFF, 18, "def.release_latency");

        $display("[TB] clean edge on short instance bit 0");
        applyStimulus(8'hFF, 8'hFE, 8);
        sw_b = 8'hFF;
        wait_out(1, 8'hFF, 6, "short.rise_latency");
        run_cycle();
        sw_b = 8'hFE;
        wait_out(1, 8'hFE, 6, "short.fall_latency");
        run_cycle();

        $display("[TB] bounce and terminal-count boundary on short bit 2");
        applyStimulus(8'hFF, 8'hFA, 8);
        applyStimulus(8'hFF, 8'hFE, 3);
        applyStimulus(8'hFF, 8'hFA, 1);
        applyStimulus(8'hFF, 8'hFE, 2);
        applyStimulus(8'hFF, 8'hFA, 8);
        check_one("short.bounce_rejected", out_b, 8'hFA);
        applyStimulus(8'hFF, 8'hFE, 3);
        applyStimulus(8'hFF, 8'hFA, 8);
        check_one("short.three_edges_rejected", out_b, 8'hFA);
        applyStimulus(8'hFF, 8'hFE, 4);
        applyStimulus(8'hFF, 8'hFA, 10);

        $display("[TB] independent bits on default instance");
        applyStimulus(8'h20, 8'h00, 22);
        applyStimulus(8'h22, 8'h00, 2);
        applyStimulus(8'h02, 8'h00, 24);
        check_one("def.independent", out_a, 8'h02);
        applyStimulus(8'h20, 8'h00, 24);
        check_one("def.same_edge", out_a, 8'h20);

        $display("[TB] toggling input every cycle");
        for (int i = 0; i < 40; i++) applyStimulus((i % 2 == 0) ? 8'hDF : 8'h20, (i % 2 == 0) ? 8'hFF : 8'h00, 1);
        check_one("def.toggle_hold", out_a, 8'h20);
        applyStimulus(8'h20, 8'h00, 20);

        $display("[TB] asynchronous reset mid-count");
        applyStimulus(8'hF0, 8'h0F, 22);
        sw_a = 8'hF8;
        repeat (4) run_cycle();
        #2;
        rst = 1'b0;
        #1;
        clear_model();
        check_one("def.async_reset_out", out_a, 8'h00);
        checkOutput();
        repeat (3) run_cycle();
        rst = 1'b1;
        wait_out(0, 8'hF8, 18, "def.post_reset_latency");

        $display("[TB] randomized stimulus");
        for (int i = 0; i < 800; i++) begin
            logic [7:0] a, b;
            a = sw_a;
            b = sw_b;
            if ($urandom_range(0, 19) == 0) a = 8'($urandom);
            b = b ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
            applyStimulus(a, b, 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
